// File: rtl/frac_fbdiv_pkg.sv
// Shared constants, types and helpers for the fractional feedback divider.
package frac_fbdiv_pkg;

   localparam int unsigned ORDER_MIN = 1;
   localparam int unsigned ORDER_MAX = 3;

   // Signed modulus word, wide enough for any legal NintW plus MASH excursion.
   typedef logic signed [31:0] mod_t;

   // Largest positive MASH output for a given order.
   function automatic int mash_max(input int unsigned order);
      return 1 << (order - 1);
   endfunction

   // Most negative MASH output for a given order.
   function automatic int mash_min(input int unsigned order);
      return 1 - (1 << (order - 1));
   endfunction

   // Upper clamp bound: largest integer ratio plus the largest MASH step.
   function automatic int div_max(input int unsigned nint_w, input int unsigned order);
      return (1 << nint_w) - 1 + mash_max(order);
   endfunction

   function automatic mod_t clamp_div(input mod_t x, input int lo, input int hi);
      if (x < mod_t'(lo)) return mod_t'(lo);
      if (x > mod_t'(hi)) return mod_t'(hi);
      return x;
   endfunction

endpackage

// File: rtl/frac_fbdiv_mash_acc.sv
// One MASH accumulator stage: sum/carry of (state + input), state advances on step.
module mash_acc #(
   parameter int unsigned W = 16
) (
   input  logic         vclk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         step_i,
   input  logic [W-1:0] in,
   output logic [W-1:0] sum,
   output logic         carry
);

   logic [W-1:0] r_acc;
   logic [W:0]   w_full;

   assign w_full = {1'b0, r_acc} + {1'b0, in};
   assign sum    = w_full[W-1:0];
   assign carry  = w_full[W];

   // Accumulator state: cleared on reset/clear, otherwise latches the new sum on a step.
   always_ff @(posedge vclk_i) begin
      if (rst_i || clr_i) r_acc <= '0;
      else if (step_i)    r_acc <= sum;
   end

endmodule

// File: rtl/frac_fbdiv.sv
// Fractional-N PLL feedback divider with MASH 1..3 dithering of the modulus.
module frac_fbdiv
   import frac_fbdiv_pkg::*;
#(
   parameter int unsigned NintW   = 8,
   parameter int unsigned NfracW  = 16,
   parameter int unsigned Order   = 3,
   parameter int unsigned NdivMin = 4
) (
   input  logic              vclk_i,
   input  logic              rst_i,
   input  logic [NintW-1:0]  ndiv_int_i,
   input  logic [NfracW-1:0] ndiv_frac_i,
   input  logic              frac_en_i,
   input  logic              load_i,
   output logic              load_ack_o,
   output logic              dclk_o,
   output logic [NintW+1:0]  div_cur_o
);

   localparam int unsigned MW     = NintW + 2;
   localparam int          DIV_HI = div_max(NintW, Order);

   if (Order < ORDER_MIN || Order > ORDER_MAX) begin : g_bad_order
      $error("frac_fbdiv: Order must be within 1..3");
   end
   if (NdivMin < Order + 1) begin : g_bad_min
      $error("frac_fbdiv: NdivMin must be at least Order+1");
   end

   logic [NintW-1:0]         r_int;
   logic [NfracW-1:0]        r_frac;
   logic                     r_frac_en;
   logic [MW-1:0]            r_count;
   logic [MW-1:0]            r_div_cur;
   logic                     r_dclk;
   logic                     r_ack;
   logic                     r_c2_d1;
   logic                     r_c3_d1;
   logic                     r_c3_d2;

   logic [2:0]               w_carry;
   logic [NfracW-1:0]        w_sum [Order];
   logic                     w_unused_sum;
   logic signed [MW-1:0]     w_mash;
   logic signed [MW-1:0]     w_next_raw;
   logic [MW-1:0]            w_next_div;
   logic [MW-1:0]            w_rst_div;
   logic                     w_term;
   logic                     w_load;
   logic                     w_toggle;
   logic                     w_clr;
   logic                     w_step;

   function automatic logic signed [MW-1:0] ext1(input logic b);
      return {{(MW-1){1'b0}}, b};
   endfunction

   assign w_term   = (r_count == r_div_cur - MW'(1));
   assign w_load   = w_term & load_i;
   assign w_toggle = w_load & (frac_en_i != r_frac_en);
   // Accumulators sit at zero whenever fractional mode is off, and restart when it toggles.
   assign w_clr    = ~r_frac_en | w_toggle;
   assign w_step   = w_term & r_frac_en;

   for (genvar k = 0; k < Order; k++) begin : g_stage
      logic [NfracW-1:0] w_in;
      if (k == 0) begin : g_first
         assign w_in = r_frac;
      end else begin : g_chain
         assign w_in = w_sum[k-1];
      end
      mash_acc #(.W(NfracW)) u_acc (
         .vclk_i (vclk_i),
         .rst_i  (rst_i),
         .clr_i  (w_clr),
         .step_i (w_step),
         .in     (w_in),
         .sum    (w_sum[k]),
         .carry  (w_carry[k])
      );
   end
   for (genvar k = Order; k < 3; k++) begin : g_pad
      assign w_carry[k] = 1'b0;
   end

   assign w_unused_sum = ^w_sum[Order-1];

   // Noise-cancel network: differentiated carries of the cascaded stages.
   always_comb begin
      w_mash = '0;
      if (r_frac_en) begin
         case (Order)
            1:       w_mash = ext1(w_carry[0]);
            2:       w_mash = ext1(w_carry[0]) + ext1(w_carry[1]) - ext1(r_c2_d1);
            default: w_mash = ext1(w_carry[0]) + ext1(w_carry[1]) - ext1(r_c2_d1)
                            + ext1(w_carry[2]) - (ext1(r_c3_d1) <<< 1) + ext1(r_c3_d2);
         endcase
      end
   end

   assign w_next_raw = signed'({2'b00, r_int}) + w_mash;
   assign w_next_div = MW'(clamp_div(mod_t'(w_next_raw), NdivMin, DIV_HI));
   assign w_rst_div  = MW'(clamp_div(mod_t'({2'b00, ndiv_int_i}), NdivMin, DIV_HI));

   // Period counter, modulus update and ratio adoption on the terminal cycle.
   always_ff @(posedge vclk_i) begin
      if (rst_i) begin
         r_int     <= ndiv_int_i;
         r_frac    <= ndiv_frac_i;
         r_frac_en <= frac_en_i;
         r_count   <= '0;
         r_div_cur <= w_rst_div;
         r_dclk    <= 1'b0;
         r_ack     <= 1'b0;
      end else begin
         r_ack <= w_load;
         if (w_term) begin
            r_count   <= '0;
            r_div_cur <= w_next_div;
            r_dclk    <= 1'b0;
            if (w_load) begin
               r_int     <= ndiv_int_i;
               r_frac    <= ndiv_frac_i;
               r_frac_en <= frac_en_i;
            end
         end else begin
            r_count <= r_count + MW'(1);
            r_dclk  <= ((r_count + MW'(1)) == (r_div_cur - MW'(1)));
         end
      end
   end

   // Carry delay taps for the differentiators; follow the accumulator clear rules.
   always_ff @(posedge vclk_i) begin
      if (rst_i || w_clr) begin
         r_c2_d1 <= 1'b0;
         r_c3_d1 <= 1'b0;
         r_c3_d2 <= 1'b0;
      end else if (w_step) begin
         r_c2_d1 <= w_carry[1];
         r_c3_d1 <= w_carry[2];
         r_c3_d2 <= r_c3_d1;
      end
   end

   assign load_ack_o = r_ack;
   assign dclk_o     = r_dclk;
   assign div_cur_o  = r_div_cur;

endmodule

// File: tb/tb_frac_fbdiv.sv
// Self-checking bench for frac_fbdiv: Order=3 and Order=1 instances share stimulus.
module tb_frac_fbdiv;

   logic        vclk  = 1'b0;
   logic        rst   = 1'b1;
   logic        load  = 1'b0;
   logic        fen   = 1'b0;
   logic [7:0]  nint  = 8'd10;
   logic [15:0] nfrac = 16'd0;
   logic        ack3, dclk3, ack1, dclk1;
   logic [9:0]  div3, div1;
   logic        rst_q = 1'b1;

   int n_checks = 0;
   int n_errs   = 0;

   // Per-DUT observation records: period lengths, modulus seen in the pulse cycle, acks.
   int cnt [2];
   int lenq0[$], lenq1[$], divq0[$], divq1[$];
   int ackp0[$], ackc0[$], ackp1[$], ackc1[$];
   int mdl[$];

   frac_fbdiv #(.NintW(8), .NfracW(16), .Order(3), .NdivMin(4)) u_dut3 (
      .vclk_i(vclk), .rst_i(rst), .ndiv_int_i(nint), .ndiv_frac_i(nfrac),
      .frac_en_i(fen), .load_i(load), .load_ack_o(ack3), .dclk_o(dclk3), .div_cur_o(div3));

   frac_fbdiv #(.NintW(8), .NfracW(16), .Order(1), .NdivMin(4)) u_dut1 (
      .vclk_i(vclk), .rst_i(rst), .ndiv_int_i(nint), .ndiv_frac_i(nfrac),
      .frac_en_i(fen), .load_i(load), .load_ack_o(ack1), .dclk_o(dclk1), .div_cur_o(div1));

   always #5 vclk = ~vclk;

   always @(posedge vclk) rst_q <= rst;

   // Monitor: cycle 0 is the first cycle after the last reset edge.
   always @(negedge vclk) begin
      if (rst_q) begin cnt[0] = 1; cnt[1] = 1; end
      else begin cnt[0]++; cnt[1]++; end
      if (ack3 === 1'b1) begin ackp0.push_back(lenq0.size()); ackc0.push_back(cnt[0]); end
      if (ack1 === 1'b1) begin ackp1.push_back(lenq1.size()); ackc1.push_back(cnt[1]); end
      if (dclk3 === 1'b1) begin lenq0.push_back(cnt[0]); divq0.push_back(int'(div3)); cnt[0] = 0; end
      if (dclk1 === 1'b1) begin lenq1.push_back(cnt[1]); divq1.push_back(int'(div1)); cnt[1] = 0; end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge vclk);
      #1;
   endtask

   function automatic int qsize(input bit sel);
      return sel ? lenq1.size() : lenq0.size();
   endfunction

   function automatic int qlen(input bit sel, input int i);
      return sel ? lenq1[i] : lenq0[i];
   endfunction

   function automatic int qdiv(input bit sel, input int i);
      return sel ? divq1[i] : divq0[i];
   endfunction

   task automatic clear_records();
      lenq0.delete(); lenq1.delete(); divq0.delete(); divq1.delete();
      ackp0.delete(); ackc0.delete(); ackp1.delete(); ackc1.delete();
   endtask

   task automatic do_reset(input int iv, input int fv, input bit fe);
      nint  = iv[7:0];
      nfrac = fv[15:0];
      fen   = fe;
      load  = 1'b0;
      rst   = 1'b1;
      tick();
      rst   = 1'b0;
      clear_records();
   endtask

   task automatic wait_pulses(input bit sel, input int n);
      int budget;
      budget = n * 300 + 50;
      for (int i = 0; i < budget && qsize(sel) < n; i++) tick();
      check("pulses_arrived", int'(qsize(sel) >= n), 1);
   endtask

   function automatic int clampv(input int x, input int ord);
      int hi;
      hi = 255 + (1 << (ord - 1));
      if (x < 4) return 4;
      if (x > hi) return hi;
      return x;
   endfunction

   // Reference: period k+1 modulus = clamp(int + MASH output of step k), step from zero state.
   task automatic model_seq(input int iv, input int fv, input bit fe, input int ord, input int n);
      int a1, a2, a3, c1, c2, c3, c2p, c3p, c3pp, m;
      a1 = 0; a2 = 0; a3 = 0; c2p = 0; c3p = 0; c3pp = 0;
      mdl.delete();
      mdl.push_back(clampv(iv, ord));
      for (int k = 1; k < n; k++) begin
         m = 0;
         if (fe) begin
            a1 = a1 + fv; c1 = a1 / 65536; a1 = a1 % 65536;
            a2 = a2 + a1; c2 = a2 / 65536; a2 = a2 % 65536;
            a3 = a3 + a2; c3 = a3 / 65536; a3 = a3 % 65536;
            case (ord)
               1:       m = c1;
               2:       m = c1 + c2 - c2p;
               default: m = c1 + (c2 - c2p) + (c3 - 2 * c3p + c3pp);
            endcase
            c2p = c2; c3pp = c3p; c3p = c3;
         end
         mdl.push_back(clampv(iv + m, ord));
      end
   endtask

   task automatic check_vs_model(input string tag, input bit sel, input int n);
      for (int i = 0; i < n && i < qsize(sel); i++) begin
         check({tag, "_len"}, qlen(sel, i), mdl[i]);
         check({tag, "_div"}, qdiv(sel, i), mdl[i]);
      end
   endtask

   initial begin
      int s, mn, mx, iv, fv;
      bit fe;

      tick(); tick();

      // Integer mode, divide by 10, one load.
      do_reset(10, 0, 0);
      check("A_rst_dclk", int'(dclk3), 0);
      check("A_rst_ack", int'(ack3), 0);
      check("A_rst_div", int'(div3), 10);
      wait_pulses(0, 3);
      load = 1'b1;
      for (int i = 0; i < 40 && ack3 !== 1'b1; i++) tick();
      check("A_ack_seen", int'(ack3), 1);
      load = 1'b0;
      wait_pulses(0, 7);
      for (int i = 0; i < 7; i++) begin
         check("A_len", qlen(0, i), 10);
         check("A_div", qdiv(0, i), 10);
      end
      check("A_ack_count", ackp0.size(), 1);
      check("A_ack_first_cycle", (ackc0.size() > 0) ? ackc0[0] : -1, 1);

      // Order-1 fractional 10.25.
      do_reset(10, 'h4000, 1);
      wait_pulses(1, 1004);
      model_seq(10, 'h4000, 1, 1, 1004);
      check_vs_model("B", 1, 1004);
      s = 0;
      for (int i = 4; i < 1004 && i < qsize(1); i++) s += qlen(1, i);
      check("B_sum1000", s, 10250);

      // Order-3 fractional 10.25.
      do_reset(10, 'h4000, 1);
      wait_pulses(0, 2049);
      model_seq(10, 'h4000, 1, 3, 2049);
      check_vs_model("C", 0, 2049);
      s = 0; mn = 1000; mx = 0;
      for (int i = 1; i < 2049 && i < qsize(0); i++) begin
         s += qlen(0, i);
         if (qlen(0, i) < mn) mn = qlen(0, i);
         if (qlen(0, i) > mx) mx = qlen(0, i);
      end
      check("C_sum2048", s, 20992);
      check("C_min_ge_7", int'(mn >= 7), 1);
      check("C_max_le_14", int'(mx <= 14), 1);

      // Load raised mid-period: 10 -> 20.
      do_reset(10, 0, 0);
      tick(); tick(); tick();
      nint = 8'd20;
      load = 1'b1;
      for (int i = 0; i < 40 && ack3 !== 1'b1; i++) tick();
      check("D_ack_seen", int'(ack3), 1);
      load = 1'b0;
      wait_pulses(0, 4);
      check("D_len0", qlen(0, 0), 10);
      check("D_len1", qlen(0, 1), 10);
      check("D_len2", qlen(0, 2), 20);
      check("D_len3", qlen(0, 3), 20);
      check("D_ack_count", ackp0.size(), 1);
      check("D_ack_after_pulse", (ackp0.size() > 0) ? ackp0[0] : -1, 1);
      check("D_ack_cycle", (ackc0.size() > 0) ? ackc0[0] : -1, 1);

      // Clamp at the bottom and top.
      do_reset(2, 0, 0);
      wait_pulses(0, 3);
      for (int i = 0; i < 3; i++) begin
         check("E_low_len", qlen(0, i), 4);
         check("E_low_div", qdiv(0, i), 4);
      end
      do_reset(255, 'hFFFF, 1);
      wait_pulses(0, 40);
      model_seq(255, 'hFFFF, 1, 3, 40);
      check_vs_model("E_high", 0, 40);
      mn = 1000; mx = 0;
      for (int i = 0; i < qsize(0); i++) begin
         if (qlen(0, i) < mn) mn = qlen(0, i);
         if (qlen(0, i) > mx) mx = qlen(0, i);
      end
      check("E_max_le_259", int'(mx <= 259), 1);
      check("E_min_ge_4", int'(mn >= 4), 1);

      // Reset at count=5, together with load.
      do_reset(10, 0, 0);
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      load = 1'b1;
      tick();
      rst = 1'b0;
      load = 1'b0;
      check("F_rst_dclk", int'(dclk3), 0);
      check("F_rst_ack", int'(ack3), 0);
      check("F_rst_div", int'(div3), 10);
      wait_pulses(0, 2);
      check("F_first_len", qlen(0, 0), 10);
      check("F_second_len", qlen(0, 1), 10);
      check("F_no_ack", ackp0.size(), 0);

      // Randomised ratios against the reference model, both orders.
      for (int r = 0; r < 4; r++) begin
         iv = int'($urandom_range(40, 2));
         fv = int'($urandom & 32'hFFFF);
         fe = 1'($urandom & 1);
         do_reset(iv, fv, fe);
         wait_pulses(0, 12);
         wait_pulses(1, 12);
         model_seq(iv, fv, fe, 3, 12);
         check_vs_model("G_o3", 0, 12);
         model_seq(iv, fv, fe, 1, 12);
         check_vs_model("G_o1", 1, 12);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/frac_fbdiv.md
Name: frac_fbdiv

Overview:
- Next-generation PLL feedback divider. Divides vclk_i by a runtime-programmable integer-plus-fraction ratio.
- A selectable-order MASH sigma-delta modulator (orders 1-3) dithers the integer modulus.
- Ratio updates go through a request/acknowledge handshake and take effect only on a period boundary.
- Sits between the VCO output and the PFD feedback input. Replaces the fixed-Ndiv integer divider.

Parameters:
- NintW, 8: width of the integer divide ratio.
- NfracW, 16: width of the fractional word; resolution is 2^-NfracW.
- Order, 3: MASH order, legal range 1..3; elaboration error outside this range.
- NdivMin, 4: minimum instantaneous modulus; must be at least Order+1.

Ports:
- vclk_i, in, 1: divider clock (VCO output).
- rst_i, in, 1: reset; synchronous, active-high, sampled on posedge vclk_i.
- ndiv_int_i, in, NintW: requested integer ratio.
- ndiv_frac_i, in, NfracW: requested fractional ratio.
- frac_en_i, in, 1: requested fractional-mode enable.
- load_i, in, 1: level request to adopt the three requested fields.
- load_ack_o, out, 1: one-cycle pulse when the requested fields are adopted.
- dclk_o, out, 1: divided clock; high for the last vclk cycle of each period.
- div_cur_o, out, NintW+2: modulus of the period in progress, unsigned.

Behaviour:
- Reset (rst_i=1 at a posedge):
  - Active registers load from ndiv_int_i, ndiv_frac_i and frac_en_i.
  - count=0, all accumulators and delay taps =0.
  - dclk_o=0, load_ack_o=0.
  - div_cur_o = clamp(ndiv_int_i).
  - Reset asserted mid-period aborts that period; no dclk_o pulse is emitted.
- Period: count runs 0..div_cur-1. dclk_o is registered 1 exactly in the cycle where count==div_cur-1, otherwise 0.
  - The first pulse after reset release occurs in cycle div_cur-1, counting the first cycle out of reset as cycle 0.
- Terminal cycle (count==div_cur-1). In this cycle only:
  - The modulator advances one step.
  - The next div_cur is computed as clamp(int_active + mash_out).
  - count returns to 0.
- MASH structure:
  - Stage k is an NfracW-bit accumulator with carry c_k.
  - Stage 1 input is frac_active; stage k>1 input is the stage k-1 sum.
  - Order 1: mash_out = c1.
  - Order 2: mash_out = c1 + c2 - c2[-1].
  - Order 3: mash_out = c1 + (c2 - c2[-1]) + (c3 - 2*c3[-1] + c3[-2]).
  - mash_out is signed, in range -(2^(Order-1)-1) .. 2^(Order-1).
  - Sum arithmetic is signed, NintW+2 bits, and never overflows.
- Clamp: result is limited to [NdivMin, 2^NintW-1+2^(Order-1)].
- frac_en_active=0:
  - mash_out forced to 0.
  - Accumulators and taps held at 0.
  - Pure integer division by clamp(int_active).
- Load handshake:
  - load_i is sampled in the terminal cycle.
  - If load_i=1 there, the active registers capture the inputs and load_ack_o=1 in the following cycle, the first cycle of the new period.
  - The new ratio governs the period after the one already computed in that terminal cycle; it uses the old values.
  - No tearing occurs mid-period.
  - Requester drops load_i after seeing ack. If load_i is still high at the next terminal cycle, it reloads and acks again.
- Accumulator state on load:
  - frac_en toggled by the load: accumulators and taps clear.
  - Otherwise they keep their state, so the ratio changes without a phase step.
- Simultaneous rst_i and load_i: reset wins; no ack is issued.

Decomposition:
- Package frac_fbdiv_pkg holds:
  - legal Order range constants;
  - the mash_out range function of Order;
  - the clamp bound function;
  - a typedef for the signed modulus word.
- Sub-module mash_acc: one accumulator stage. Ports are vclk_i, rst_i, clr_i, step_i, in, sum, carry.
- The top instantiates Order copies of mash_acc via generate and implements the noise-cancel adder and the counter.

Test Plan:
- Integer mode: int=10, frac_en=0, load once after reset.
  - Required: dclk_o period exactly 10 cycles, 1-cycle high; div_cur_o=10 constant; no ack except for the load.
- Order=1 fractional: int=10, frac=0x4000, frac_en=1.
  - Required: moduli repeat {10,10,10,11}; 1000 periods sum to exactly 10250 cycles.
- Order=3 fractional: int=10, frac=0x4000, frac_en=1.
  - Required: every modulus in [7,14]; 65536 consecutive periods sum to exactly 671744 cycles.
- Load mid-period: int 10 -> 20 with load_i raised at count=3.
  - Required: ack one cycle after that period's terminal count; the next period is still 10; the following period is 20.
- Clamp: int=2, frac_en=0.
  - Required: period is 4 (NdivMin).
  - Then int=255, frac=0xFFFF, Order=3: no modulus exceeds 259 and none falls below 4.
- Reset mid-period: rst_i high at count=5 of a 10-period.
  - Required: no dclk_o pulse; after release the first pulse lands in cycle 9.
  - Reset together with load_i: no load_ack_o.
